game_input_scheduler: RTL and testbench

Sequences player and timer events into the single-cycle action pulses consumed by `game_control`. Sits between the debounced keyboard decoder and `game_control`. Converts held key levels into press events, delayed auto-shift (DAS) repeats and soft-drop repeats. Merges these with the gravity tick, then arbitrates so that at most one action reaches `game_control` per grant, and only when it reports ready.

---
 rtl/game_input_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_game_input_scheduler.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_input_scheduler.sv
// Turns debounced key levels and the gravity strobe into one-cycle action pulses for game_control.
// Each action is separated from the next by a gap cycle, and actions are granted by priority.
module game_input_scheduler #(
  parameter int DAS_FRAMES = 10,
  parameter int ARR_FRAMES = 2,
  parameter int SDR_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       gravity_tick,
  input  logic       ready,
  input  logic       left_lvl,
  input  logic       right_lvl,
  input  logic       down_lvl,
  input  logic       cw_lvl,
  input  logic       ccw_lvl,
  input  logic       drop_lvl,
  input  logic       hold_lvl,
  output logic       key_left,
  output logic       key_right,
  output logic       key_down,
  output logic       key_rotate_cw,
  output logic       key_rotate_ccw,
  output logic       key_drop,
  output logic       key_hold,
  output logic       tick_game,
  output logic       key_drop_held,
  output logic [7:0] pending
);

  typedef enum logic [1:0] {H_NONE, H_LEFT, H_RIGHT} hdir_t;
  typedef enum logic {ARB_IDLE, ARB_GAP} arb_t;

  localparam logic [7:0] DAS_LOAD = 8'(DAS_FRAMES);
  localparam logic [7:0] ARR_LOAD = 8'(ARR_FRAMES);
  localparam logic [7:0] SDR_LOAD = 8'(SDR_FRAMES);

  // Bit positions shared by pending, set/clear vectors and the pulse register
  localparam int B_HOLD  = 7;
  localparam int B_DROP  = 6;
  localparam int B_LEFT  = 3;
  localparam int B_RIGHT = 2;
  localparam int B_DOWN  = 1;
  localparam int B_GRAV  = 0;

  logic [6:0] lvl, prev, press;
  logic [7:0] pend, pend_n, set_v, clr_v, gnt, pulse;
  hdir_t      hdir, hdir_n;
  logic [7:0] hcnt, hcnt_n, vcnt, vcnt_n;
  logic       das_left, das_right, sdr_fire;
  arb_t       state, state_n;
  logic       drop_held_q;

  assign lvl   = {hold_lvl, drop_lvl, cw_lvl, ccw_lvl, left_lvl, right_lvl, down_lvl};
  assign press = lvl & ~prev;

  // prev tracks lvl in and out of reset, so keys held through reset never register a press
  always_ff @(posedge clk) begin
    prev <= lvl;
  end

  always_comb begin
    hdir_n    = hdir;
    hcnt_n    = hcnt;
    das_left  = 1'b0;
    das_right = 1'b0;
    if (press[B_LEFT - 1]) begin
      hdir_n = H_LEFT;
      hcnt_n = DAS_LOAD;
    end else if (press[B_RIGHT - 1]) begin
      hdir_n = H_RIGHT;
      hcnt_n = DAS_LOAD;
    end else begin
      case (hdir)
        H_LEFT: begin
          if (!left_lvl) begin
            hdir_n = right_lvl ? H_RIGHT : H_NONE;
            hcnt_n = right_lvl ? DAS_LOAD : 8'd0;
          end else if (frame_tick) begin
            if (hcnt <= 8'd1) begin
              das_left = 1'b1;
              hcnt_n   = ARR_LOAD;
            end else begin
              hcnt_n = hcnt - 8'd1;
            end
          end
        end
        H_RIGHT: begin
          if (!right_lvl) begin
            hdir_n = left_lvl ? H_LEFT : H_NONE;
            hcnt_n = left_lvl ? DAS_LOAD : 8'd0;
          end else if (frame_tick) begin
            if (hcnt <= 8'd1) begin
              das_right = 1'b1;
              hcnt_n    = ARR_LOAD;
            end else begin
              hcnt_n = hcnt - 8'd1;
            end
          end
        end
        default: begin
          hcnt_n = hcnt;
        end
      endcase
    end
  end

  always_comb begin
    vcnt_n   = vcnt;
    sdr_fire = 1'b0;
    if (press[B_DOWN - 1]) begin
      vcnt_n = SDR_LOAD;
    end else if (!down_lvl) begin
      vcnt_n = 8'd0;
    end else if (frame_tick) begin
      if (vcnt <= 8'd1) begin
        sdr_fire = 1'b1;
        vcnt_n   = SDR_LOAD;
      end else begin
        vcnt_n = vcnt - 8'd1;
      end
    end
  end

  // Highest set pending bit wins; the loop leaves the top-most one in gnt
  always_comb begin
    state_n = state;
    gnt     = 8'd0;
    if (state == ARB_IDLE) begin
      if (ready && (pend != 8'd0)) begin
        for (int i = 0; i < 8; i++) begin
          if (pend[i]) begin
            gnt    = 8'd0;
            gnt[i] = 1'b1;
          end
        end
        state_n = ARB_GAP;
      end
    end else begin
      state_n = ARB_IDLE;
    end
  end

  always_comb begin
    clr_v = gnt;
    if (gnt[B_DROP]) begin
      clr_v[B_DOWN] = 1'b1;
      clr_v[B_GRAV] = 1'b1;
    end
    if (gnt[B_HOLD]) begin
      clr_v[B_LEFT]  = 1'b1;
      clr_v[B_RIGHT] = 1'b1;
      clr_v[B_DOWN]  = 1'b1;
    end
    set_v          = {press, gravity_tick};
    set_v[B_LEFT]  = set_v[B_LEFT] | das_left;
    set_v[B_RIGHT] = set_v[B_RIGHT] | das_right;
    set_v[B_DOWN]  = set_v[B_DOWN] | sdr_fire;
    pend_n         = (pend & ~clr_v) | set_v;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend        <= 8'd0;
      pulse       <= 8'd0;
      hdir        <= H_NONE;
      hcnt        <= 8'd0;
      vcnt        <= 8'd0;
      state       <= ARB_IDLE;
      drop_held_q <= 1'b0;
    end else begin
      pend        <= pend_n;
      pulse       <= gnt;
      hdir        <= hdir_n;
      hcnt        <= hcnt_n;
      vcnt        <= vcnt_n;
      state       <= state_n;
      drop_held_q <= drop_lvl;
    end
  end

  assign key_hold       = pulse[7];
  assign key_drop       = pulse[6];
  assign key_rotate_cw  = pulse[5];
  assign key_rotate_ccw = pulse[4];
  assign key_left       = pulse[3];
  assign key_right      = pulse[2];
  assign key_down       = pulse[1];
  assign tick_game      = pulse[0];
  assign key_drop_held  = drop_held_q;
  assign pending        = pend;

endmodule

// File: tb/tb_game_input_scheduler.sv
// Directed bench for game_input_scheduler: each task drives one scenario and checks its own results.
module tb_game_input_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic frame_tick = 1'b0, gravity_tick = 1'b0, ready = 1'b1;
  logic left_lvl = 1'b0, right_lvl = 1'b0, down_lvl = 1'b0, cw_lvl = 1'b0;
  logic ccw_lvl = 1'b0, drop_lvl = 1'b0, hold_lvl = 1'b0;
  logic key_left, key_right, key_down, key_rotate_cw, key_rotate_ccw;
  logic key_drop, key_hold, tick_game, key_drop_held;
  logic [7:0] pending;

  int tests_run = 0;
  int tests_failed = 0;
  int cnt [8] = '{default: 0};
  int multi_hot = 0;
  int cyc = 0;
  int log_id [$];
  int log_cyc [$];

  always #5 clk = ~clk;

  game_input_scheduler #(.DAS_FRAMES(10), .ARR_FRAMES(2), .SDR_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .gravity_tick(gravity_tick), .ready(ready),
    .left_lvl(left_lvl), .right_lvl(right_lvl), .down_lvl(down_lvl), .cw_lvl(cw_lvl),
    .ccw_lvl(ccw_lvl), .drop_lvl(drop_lvl), .hold_lvl(hold_lvl),
    .key_left(key_left), .key_right(key_right), .key_down(key_down),
    .key_rotate_cw(key_rotate_cw), .key_rotate_ccw(key_rotate_ccw), .key_drop(key_drop),
    .key_hold(key_hold), .tick_game(tick_game), .key_drop_held(key_drop_held), .pending(pending)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse log indexed like pending: 7 hold, 6 drop, 5 cw, 4 ccw, 3 left, 2 right, 1 down, 0 tick
  always @(negedge clk) begin
    logic [7:0] o;
    o = {key_hold, key_drop, key_rotate_cw, key_rotate_ccw, key_left, key_right, key_down, tick_game};
    if ($countones(o) > 1) multi_hot++;
    for (int i = 0; i < 8; i++) begin
      if (o[i] === 1'b1) begin
        cnt[i]++;
        log_id.push_back(i);
        log_cyc.push_back(cyc);
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    wait_cyc(1);
    frame_tick = 1'b0;
    wait_cyc(3);
  endtask

  task automatic test_reset();
    int b [8];
    rst = 1'b0; left_lvl = 1'b1; ready = 1'b1;
    wait_cyc(3);
    tests_run++;
    if ({key_hold, key_drop, key_rotate_cw, key_rotate_ccw, key_left, key_right, key_down,
         tick_game, key_drop_held, pending} !== 17'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got pending=%h pulses=%b held=%b, expected all 0", pending,
               {key_hold, key_drop, key_rotate_cw, key_rotate_ccw, key_left, key_right, key_down, tick_game},
               key_drop_held);
    end
    b = cnt;
    rst = 1'b1;
    wait_cyc(5);
    tests_run++;
    if (cnt[3] - b[3] !== 0) begin
      tests_failed++;
      $display("[TB] FAIL reset_held_left: got %0d key_left pulses, expected 0", cnt[3] - b[3]);
    end
    tests_run++;
    if (pending !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL reset_pending: got %h, expected 00", pending);
    end
    left_lvl = 1'b0;
    wait_cyc(2);
  endtask

  task automatic test_simultaneous();
    int lb;
    lb = log_id.size();
    cw_lvl = 1'b1; drop_lvl = 1'b1;
    wait_cyc(8);
    tests_run++;
    if (log_id.size() - lb !== 2) begin
      tests_failed++;
      $display("[TB] FAIL simul_count: got %0d pulses, expected 2", log_id.size() - lb);
    end
    tests_run++;
    if (log_id.size() < lb + 2) begin
      tests_failed++;
      $display("[TB] FAIL simul_order: got %0d pulses, expected drop then cw", log_id.size() - lb);
    end else if (log_id[lb] !== 6 || log_id[lb+1] !== 5 || log_cyc[lb+1] - log_cyc[lb] !== 2) begin
      tests_failed++;
      $display("[TB] FAIL simul_order: got ids %0d,%0d spacing %0d, expected 6,5 spacing 2",
               log_id[lb], log_id[lb+1], log_cyc[lb+1] - log_cyc[lb]);
    end
    tests_run++;
    if (key_drop_held !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL simul_drop_held: got %b, expected 1", key_drop_held);
    end
    cw_lvl = 1'b0; drop_lvl = 1'b0;
    wait_cyc(3);
  endtask

  task automatic test_das();
    int b [8];
    b = cnt;
    left_lvl = 1'b1;
    wait_cyc(4);
    for (int f = 1; f <= 9; f++) frame();
    tests_run++;
    if (cnt[3] - b[3] !== 1) begin
      tests_failed++;
      $display("[TB] FAIL das_before_expiry: got %0d key_left, expected 1", cnt[3] - b[3]);
    end
    frame();
    tests_run++;
    if (cnt[3] - b[3] !== 2) begin
      tests_failed++;
      $display("[TB] FAIL das_first_repeat: got %0d key_left, expected 2", cnt[3] - b[3]);
    end
    for (int f = 11; f <= 14; f++) frame();
    tests_run++;
    if (cnt[3] - b[3] !== 4 || cnt[2] - b[2] !== 0 || cnt[1] - b[1] !== 0) begin
      tests_failed++;
      $display("[TB] FAIL das_total: got left=%0d right=%0d down=%0d, expected 4,0,0",
               cnt[3] - b[3], cnt[2] - b[2], cnt[1] - b[1]);
    end
    left_lvl = 1'b0;
    wait_cyc(3);
  endtask

  task automatic test_das_coincident();
    int b [8];
    b = cnt;
    right_lvl = 1'b1; frame_tick = 1'b1;
    wait_cyc(1);
    frame_tick = 1'b0;
    wait_cyc(3);
    for (int f = 1; f <= 9; f++) frame();
    tests_run++;
    if (cnt[2] - b[2] !== 1) begin
      tests_failed++;
      $display("[TB] FAIL das_coincident_tick: got %0d key_right, expected 1", cnt[2] - b[2]);
    end
    frame();
    tests_run++;
    if (cnt[2] - b[2] !== 2) begin
      tests_failed++;
      $display("[TB] FAIL das_coincident_repeat: got %0d key_right, expected 2", cnt[2] - b[2]);
    end
    right_lvl = 1'b0;
    wait_cyc(3);
  endtask

  task automatic test_switch();
    int b [8];
    b = cnt;
    left_lvl = 1'b1;
    wait_cyc(4);
    for (int f = 1; f <= 4; f++) frame();
    right_lvl = 1'b1;
    wait_cyc(4);
    for (int f = 5; f <= 8; f++) frame();
    tests_run++;
    if (cnt[3] - b[3] !== 1 || cnt[2] - b[2] !== 1) begin
      tests_failed++;
      $display("[TB] FAIL switch_right_press: got left=%0d right=%0d, expected 1,1",
               cnt[3] - b[3], cnt[2] - b[2]);
    end
    right_lvl = 1'b0;
    wait_cyc(4);
    tests_run++;
    if (cnt[3] - b[3] !== 1) begin
      tests_failed++;
      $display("[TB] FAIL switch_no_immediate: got %0d key_left, expected 1", cnt[3] - b[3]);
    end
    for (int f = 9; f <= 17; f++) frame();
    tests_run++;
    if (cnt[3] - b[3] !== 1) begin
      tests_failed++;
      $display("[TB] FAIL switch_early_left: got %0d key_left, expected 1", cnt[3] - b[3]);
    end
    frame();
    tests_run++;
    if (cnt[3] - b[3] !== 2 || cnt[2] - b[2] !== 1) begin
      tests_failed++;
      $display("[TB] FAIL switch_left_das: got left=%0d right=%0d, expected 2,1",
               cnt[3] - b[3], cnt[2] - b[2]);
    end
    left_lvl = 1'b0;
    wait_cyc(3);
  endtask

  task automatic test_soft_drop();
    int b [8];
    b = cnt;
    down_lvl = 1'b1;
    wait_cyc(4);
    for (int f = 1; f <= 4; f++) frame();
    tests_run++;
    if (cnt[1] - b[1] !== 3) begin
      tests_failed++;
      $display("[TB] FAIL soft_drop_repeat: got %0d key_down, expected 3", cnt[1] - b[1]);
    end
    down_lvl = 1'b0;
    wait_cyc(3);
  endtask

  task automatic test_ready_hold();
    int lb;
    ready = 1'b0;
    lb = log_id.size();
    for (int k = 0; k < 3; k++) begin
      gravity_tick = 1'b1; wait_cyc(1);
      gravity_tick = 1'b0; wait_cyc(1);
    end
    for (int k = 0; k < 2; k++) begin
      cw_lvl = 1'b1; wait_cyc(2);
      cw_lvl = 1'b0; wait_cyc(2);
    end
    tests_run++;
    if (pending !== 8'h21 || log_id.size() != lb) begin
      tests_failed++;
      $display("[TB] FAIL ready_low_pending: got %h with %0d pulses, expected 21 with 0",
               pending, log_id.size() - lb);
    end
    ready = 1'b1;
    wait_cyc(8);
    tests_run++;
    if (log_id.size() != lb + 2) begin
      tests_failed++;
      $display("[TB] FAIL ready_release_count: got %0d pulses, expected 2", log_id.size() - lb);
    end else if (log_id[lb] !== 5 || log_id[lb+1] !== 0) begin
      tests_failed++;
      $display("[TB] FAIL ready_release_order: got ids %0d,%0d, expected 5,0", log_id[lb], log_id[lb+1]);
    end
    tests_run++;
    if (pending !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL ready_release_pending: got %h, expected 00", pending);
    end
  endtask

  task automatic test_drop_supersede();
    int lb;
    ready = 1'b0;
    lb = log_id.size();
    down_lvl = 1'b1; wait_cyc(2);
    gravity_tick = 1'b1; wait_cyc(1);
    gravity_tick = 1'b0; wait_cyc(1);
    drop_lvl = 1'b1;
    tests_run++;
    if (key_drop_held !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL drop_held_lag: got %b, expected 0", key_drop_held);
    end
    wait_cyc(1);
    tests_run++;
    if (key_drop_held !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL drop_held_rise: got %b, expected 1", key_drop_held);
    end
    wait_cyc(1);
    tests_run++;
    if (pending !== 8'h43) begin
      tests_failed++;
      $display("[TB] FAIL drop_pending_before: got %h, expected 43", pending);
    end
    ready = 1'b1;
    wait_cyc(6);
    tests_run++;
    if (log_id.size() != lb + 1 || pending !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL drop_supersede: got %0d pulses, pending %h, expected 1 pulse, pending 00",
               log_id.size() - lb, pending);
    end else if (log_id[lb] !== 6) begin
      tests_failed++;
      $display("[TB] FAIL drop_supersede_id: got id %0d, expected 6", log_id[lb]);
    end
    drop_lvl = 1'b0;
    wait_cyc(1);
    tests_run++;
    if (key_drop_held !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL drop_held_fall: got %b, expected 0", key_drop_held);
    end
    down_lvl = 1'b0;
    wait_cyc(2);
  endtask

  task automatic test_hold_clear();
    int lb;
    ready = 1'b0;
    lb = log_id.size();
    left_lvl = 1'b1; down_lvl = 1'b1; wait_cyc(2);
    hold_lvl = 1'b1; cw_lvl = 1'b1; wait_cyc(2);
    tests_run++;
    if (pending !== 8'hAA) begin
      tests_failed++;
      $display("[TB] FAIL hold_pending_before: got %h, expected aa", pending);
    end
    ready = 1'b1;
    wait_cyc(8);
    tests_run++;
    if (log_id.size() != lb + 2 || pending !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL hold_clear: got %0d pulses, pending %h, expected 2 pulses, pending 00",
               log_id.size() - lb, pending);
    end else if (log_id[lb] !== 7 || log_id[lb+1] !== 5) begin
      tests_failed++;
      $display("[TB] FAIL hold_clear_order: got ids %0d,%0d, expected 7,5", log_id[lb], log_id[lb+1]);
    end
    left_lvl = 1'b0; down_lvl = 1'b0; hold_lvl = 1'b0; cw_lvl = 1'b0;
    wait_cyc(3);
  endtask

  task automatic test_exclusive();
    tests_run++;
    if (multi_hot !== 0) begin
      tests_failed++;
      $display("[TB] FAIL exclusive_pulses: got %0d multi-hot cycles, expected 0", multi_hot);
    end
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_das();
    test_das_coincident();
    test_switch();
    test_soft_drop();
    test_ready_hold();
    test_drop_supersede();
    test_hold_clear();
    test_exclusive();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
